ro_puf_ctrl: RTL
================

# ro_puf_ctrl

Measurement controller for the ring-oscillator PUF array. On a challenge it selects two `rOsc` cells, clears their toggle flops, and enables both for a fixed window of system clocks. It counts synchronized rising edges of each cell's `dffout` and compares the two counts to produce one response bit. It sits between the challenge/response host logic and the `N_RO` ring-oscillator instances.

## Interface
Parameters:
- `N_RO`, 16: number of ring-oscillator cells; power of two, at least 2.
- `SEL_W`, `$clog2(N_RO)`: challenge index width.
- `CNT_W`, 16: edge-counter width.
- `WINDOW`, 1024: count-window length in clk cycles; at least 1.
- `RST_CYC`, 4: clear-phase length in clk cycles; at least 2.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a measurement; sampled only in IDLE.
- `challenge_a`, in, `SEL_W`: index of RO A.
- `challenge_b`, in, `SEL_W`: index of RO B.
- `busy`, out, 1: high from the cycle after an accepted start through DONE.
- `done`, out, 1: one-cycle pulse; results valid from this cycle.
- `err`, out, 1: set with `done` when `challenge_a == challenge_b`.
- `response`, out, 1: 1 iff `count_a > count_b`.
- `count_a`, out, `CNT_W`: edge count of RO A.
- `count_b`, out, `CNT_W`: edge count of RO B.
- `ro_enable`, out, `N_RO`: per-cell enable.
- `ro_reset`, out, `N_RO`: per-cell reset.
- `ro_dffout`, in, `N_RO`: per-cell toggle output; asynchronous to clk.

## Operation
- FSM states: IDLE, CLEAR, COUNT, DRAIN, DONE.
- **IDLE, no start:** `start` low keeps the FSM in IDLE.
- **IDLE, start with A ≠ B:** latch both indices and go to CLEAR.
- **IDLE, start with A = B:** latch the indices and go directly to DONE with `err=1`, `response=0`, both counts 0.
- **CLEAR (`RST_CYC` cycles):**
  - `ro_enable` and `ro_reset` are high for bits A and B only.
  - The ring must run for the cell's own-clocked flop to clear; with enable low the ring is static and its reset never takes effect.
  - Both counters are held at 0 and edge detection is suppressed.
- **COUNT (`WINDOW` cycles):**
  - `ro_reset` is low and `ro_enable` is high for A and B.
  - Each cycle with a synchronized rising edge of `dffout` increments that cell's counter.
  - Counters saturate at 2^`CNT_W`−1 and do not wrap.
- **DRAIN (3 cycles):**
  - All `ro_enable` bits are low.
  - Counting continues so edges still in the 2-flop synchronizer are captured.
- **DONE (1 cycle):**
  - `done=1`, and `response`, `count_a` and `count_b` are registered.
  - The FSM returns to IDLE.
  - Results and `err` hold until the next accepted start, which clears `err`.
- Tie (`count_a == count_b`) gives `response=0`.
- `start` and challenge changes while busy are ignored, as is a start in the DONE cycle.
- All `ro_enable` and `ro_reset` bits are 0 outside CLEAR and COUNT. Unselected bits are always 0.
- **Reset:** `reset` high in any state forces IDLE on the next edge. At that point all outputs are 0 (`busy`, `done`, `err`, `response`, both counts, `ro_enable`, `ro_reset`), and synchronizers and counters are cleared. Reset mid-measurement discards the measurement with no `done`.
- **Integration constraint:** the `dffout` high and low phases must each exceed 2 clk periods for counts to be exact. Meeting this (ring length or clk choice) is the integrator's responsibility.

## Timing
- `start` sampled at edge T: CLEAR occupies T+1 … T+`RST_CYC`.
- COUNT occupies T+`RST_CYC`+1 … T+`RST_CYC`+`WINDOW`.
- DRAIN occupies the next 3 cycles.
- `done` is high at cycle T+`RST_CYC`+`WINDOW`+4. Latency is `RST_CYC`+`WINDOW`+4 cycles.
- The `err` path has `done` at T+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Synchronizer depth is 2; the edge detector adds 1 register.
- An edge arriving in the last COUNT cycle is counted by the end of DRAIN.

## Structure
- Package `ro_puf_pkg`:
  - state enum
  - `SYNC_STAGES=2`
  - `DRAIN_CYC=3`
- Sub-module `ro_edge_counter`:
  - 2-flop synchronizer, rising-edge detect and `CNT_W`-bit saturating counter.
  - Inputs: `clk`, `reset`, `clr`, `cnt_en`, `sig`.
  - Instantiated twice. The controller muxes `ro_dffout[A]` and `ro_dffout[B]` into the instances from the latched indices.

## Test plan
- **Nominal compare:** bench RO models with `dffout` periods of 8 clk (A=3) and 10 clk (B=7); `WINDOW=1024`, `RST_CYC=4`, start at T. Expect:
  - `done` at T+1032.
  - `count_a` 128±1, `count_b` 102±1, `response=1`.
  - `ro_enable` = 0x0088 only during CLEAR and COUNT.
- **Swapped challenge:** same models with A=7, B=3 → `response=0`. A second run with equal periods → `response=0`.
- **Equal indices:** A=B=5 → at T+1 expect `done=1`, `err=1`, `response=0`, counts 0, and `ro_enable` never asserted.
- **Saturation:** `CNT_W=4` with a period-6 RO → `count_a=15`, no wrap.
- **Reset mid-COUNT:** assert `reset` at cycle T+200 →
  - all outputs 0 on the next edge
  - no `done` pulse
  - a new start afterwards yields correct counts.
- **Start while busy:** toggle `start` and challenges during COUNT → ignored. Indices, latency and results are unchanged.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF measurement controller.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int SYNC_STAGES = 2;
    localparam int DRAIN_CYC   = 3;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one asynchronous ring-oscillator output, detects rising edges
// and counts them in a saturating counter.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             sig,
    output logic [CNT_W-1:0] count
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_rise;
    logic                   w_sat;

    // The synchronizer keeps running during clr so it has settled to the
    // freshly reset cell state by the time counting is enabled.
    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev & ~clr;
    assign w_sat  = &r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (clr)
                r_cnt <= '0;
            else if (cnt_en && w_rise && !w_sat)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign count = r_cnt;

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF measurement controller: clears and runs two selected
// cells for a fixed window, counts their edges and compares the counts.
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int N_RO    = 16,
    parameter int SEL_W   = $clog2(N_RO),
    parameter int CNT_W   = 16,
    parameter int WINDOW  = 1024,
    parameter int RST_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEL_W-1:0] challenge_a,
    input  logic [SEL_W-1:0] challenge_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             response,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
    output logic [N_RO-1:0]  ro_enable,
    output logic [N_RO-1:0]  ro_reset,
    input  logic [N_RO-1:0]  ro_dffout
);

    localparam int TMR_W = $clog2(WINDOW + RST_CYC + DRAIN_CYC + 1);

    state_t           r_state, w_next;
    logic [TMR_W-1:0] r_tmr;
    logic [SEL_W-1:0] r_sel_a, r_sel_b, w_sel_a, w_sel_b;
    logic             w_accept, w_same;
    logic [N_RO-1:0]  w_mask;
    logic [CNT_W-1:0] w_cnt_a, w_cnt_b;
    logic             r_busy, r_done, r_err, r_resp;
    logic [CNT_W-1:0] r_count_a, r_count_b;
    logic [N_RO-1:0]  r_en, r_rst;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_same   = (challenge_a == challenge_b);
    assign w_sel_a  = w_accept ? challenge_a : r_sel_a;
    assign w_sel_b  = w_accept ? challenge_b : r_sel_b;
    assign w_mask   = (N_RO'(1) << w_sel_a) | (N_RO'(1) << w_sel_b);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_same ? S_DONE : S_CLEAR;
            S_CLEAR: if (r_tmr == TMR_W'(RST_CYC - 1))   w_next = S_COUNT;
            S_COUNT: if (r_tmr == TMR_W'(WINDOW - 1))    w_next = S_DRAIN;
            S_DRAIN: if (r_tmr == TMR_W'(DRAIN_CYC - 1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_next;
            r_tmr   <= (w_next != r_state) ? '0 : r_tmr + TMR_W'(1);
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_a   <= '0;
            r_sel_b   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_resp    <= 1'b0;
            r_count_a <= '0;
            r_count_b <= '0;
            r_en      <= '0;
            r_rst     <= '0;
        end else begin
            r_sel_a <= w_sel_a;
            r_sel_b <= w_sel_b;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            r_en    <= (w_next == S_CLEAR || w_next == S_COUNT) ? w_mask : '0;
            r_rst   <= (w_next == S_CLEAR) ? w_mask : '0;
            if (w_accept) begin
                r_err <= w_same;
                if (w_same) begin
                    r_resp    <= 1'b0;
                    r_count_a <= '0;
                    r_count_b <= '0;
                end
            end else if (r_state == S_DRAIN && w_next == S_DONE) begin
                r_resp    <= (w_cnt_a > w_cnt_b);
                r_count_a <= w_cnt_a;
                r_count_b <= w_cnt_b;
            end
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .reset  (reset),
        .clr    (r_state == S_CLEAR),
        .cnt_en (r_state == S_COUNT || r_state == S_DRAIN),
        .sig    (ro_dffout[r_sel_a]),
        .count  (w_cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .reset  (reset),
        .clr    (r_state == S_CLEAR),
        .cnt_en (r_state == S_COUNT || r_state == S_DRAIN),
        .sig    (ro_dffout[r_sel_b]),
        .count  (w_cnt_b)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign response  = r_resp;
    assign count_a   = r_count_a;
    assign count_b   = r_count_b;
    assign ro_enable = r_en;
    assign ro_reset  = r_rst;

endmodule
